trellis_ff_pipe: RTL and testbench



---
 rtl/trellis_ff_pipe_pkg.sv | 11 +
 rtl/trellis_ff_pipe_stage.sv | 30 +++
 rtl/trellis_ff_pipe.sv | 54 +++++
 tb/tb_trellis_ff_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/trellis_ff_pipe_pkg.sv
// trellis_pkg: shared types and helpers for the trellis_ff_pipe register chain.
package trellis_pkg;
    typedef enum logic {REGSET_RESET, REGSET_SET} regset_t;
    localparam int MAX_WIDTH = 4096;
    function automatic logic [MAX_WIDTH-1:0] regset_value(regset_t rs, int width);
        return rs == REGSET_SET ? {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width) : '0;
    endfunction
    function automatic int fill_width(int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/trellis_ff_pipe_stage.sv
// trellis_ff_stage: one WIDTH-bit register with valid bit, clock enable and local set/reset.
module trellis_ff_stage
    import trellis_pkg::*;
#(
    parameter int    WIDTH       = 8,
    parameter string REGSET      = "RESET",
    parameter int    LSR_OVER_CE = 1
) (
    input  logic             clk,
    input  logic             lsr,
    input  logic             sp,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);
    localparam regset_t RS = REGSET == "SET" ? REGSET_SET : REGSET_RESET;
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(regset_value(RS, WIDTH));
    // valid always clears on LSR; data only when LSR may override the enable
    always_ff @(posedge clk) begin
        if (lsr) begin
            q_valid <= 1'b0;
            q       <= (LSR_OVER_CE != 0 || sp) ? RST_VAL : q;
        end else if (load) begin
            q_valid <= d_valid;
            q       <= d;
        end
    end
endmodule

// File: rtl/trellis_ff_pipe.sv
// trellis_ff_pipe: DEPTH-stage WIDTH-bit enabled register pipe with valid tracking and occupancy.
// Optional TRELLIS_FF_PIPE_BUBBLE_COLLAPSE_EN lets invalid stages fill while SP is low.
module trellis_ff_pipe
    import trellis_pkg::*;
#(
    parameter int    WIDTH       = 8,
    parameter int    DEPTH       = 3,
    parameter string REGSET      = "RESET",
    parameter int    LSR_OVER_CE = 1
) (
    input  logic                          CLK,
    input  logic                          LSR,
    input  logic                          SP,
    input  logic [WIDTH-1:0]              DI,
    input  logic                          DI_VALID,
    output logic                          DI_READY,
    output logic [WIDTH-1:0]              Q,
    output logic                          Q_VALID,
    output logic [fill_width(DEPTH)-1:0]  FILL
);
    localparam int FW = fill_width(DEPTH);
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
`ifdef TRELLIS_FF_PIPE_BUBBLE_COLLAPSE_EN
    // a stage may load whenever some stage at or after it has room
    always_comb begin
        ready[DEPTH-1] = SP | ~valid[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) ready[i] = ~valid[i] | ready[i+1];
    end
`else
    assign ready = {DEPTH{SP}};
`endif
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_head
            trellis_ff_stage #(.WIDTH(WIDTH), .REGSET(REGSET), .LSR_OVER_CE(LSR_OVER_CE)) u_stage (
                .clk(CLK), .lsr(LSR), .sp(SP), .load(ready[s]),
                .d(DI), .d_valid(DI_VALID), .q(data[s]), .q_valid(valid[s])
            );
        end else begin : g_body
            trellis_ff_stage #(.WIDTH(WIDTH), .REGSET(REGSET), .LSR_OVER_CE(LSR_OVER_CE)) u_stage (
                .clk(CLK), .lsr(LSR), .sp(SP), .load(ready[s]),
                .d(data[s-1]), .d_valid(valid[s-1]), .q(data[s]), .q_valid(valid[s])
            );
        end
    end
    always_comb begin
        FILL = '0;
        for (int i = 0; i < DEPTH; i++) FILL = FILL + FW'(valid[i]);
    end
    assign DI_READY = ready[0];
    assign Q        = data[DEPTH-1];
    assign Q_VALID  = valid[DEPTH-1];
endmodule

// File: tb/tb_trellis_ff_pipe.sv
// tb_trellis_ff_pipe: directed bench for trellis_ff_pipe with a per-cycle queue-level model.
module tb_trellis_ff_pipe;
    localparam int W = 8;
    localparam int D = 3;
    typedef struct packed {
        logic [D-1:0][W-1:0] d;
        logic [D-1:0]        v;
    } mstate_t;
    logic         clk = 1'b0, lsr = 1'b0, sp = 1'b0, di_valid = 1'b0;
    logic [W-1:0] di = '0;
    logic         a_ready, a_qv, b_ready, b_qv;
    logic [W-1:0] a_q, b_q;
    logic [1:0]   a_fill, b_fill;
    mstate_t      ma, mb;
    bit           chk = 1'b0;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    trellis_ff_pipe #(.WIDTH(W), .DEPTH(D), .REGSET("SET"), .LSR_OVER_CE(1)) u_dut_a (
        .CLK(clk), .LSR(lsr), .SP(sp), .DI(di), .DI_VALID(di_valid),
        .DI_READY(a_ready), .Q(a_q), .Q_VALID(a_qv), .FILL(a_fill)
    );
    trellis_ff_pipe #(.WIDTH(W), .DEPTH(D), .REGSET("RESET"), .LSR_OVER_CE(0)) u_dut_b (
        .CLK(clk), .LSR(lsr), .SP(sp), .DI(di), .DI_VALID(di_valid),
        .DI_READY(b_ready), .Q(b_q), .Q_VALID(b_qv), .FILL(b_fill)
    );

    function automatic mstate_t step(mstate_t s, bit over_ce, logic [W-1:0] rv,
                                     logic l, logic e, logic [W-1:0] din, logic dv);
        mstate_t n = s;
        int k = -1;
        if (l) begin
            n.v = '0;
            if (over_ce || e) n.d = {D{rv}};
        end else if (e) begin
            n.d = {s.d[D-2:0], din};
            n.v = {s.v[D-2:0], dv};
        end else begin
`ifdef TRELLIS_FF_PIPE_BUBBLE_COLLAPSE_EN
            for (int i = 0; i < D; i++) if (!s.v[i]) k = i;
            for (int i = 1; i < D; i++) if (i <= k) begin
                n.d[i] = s.d[i-1];
                n.v[i] = s.v[i-1];
            end
            if (k >= 0) begin
                n.d[0] = din;
                n.v[0] = dv;
            end
`endif
        end
        return n;
    endfunction

    function automatic logic exp_ready(mstate_t m);
`ifdef TRELLIS_FF_PIPE_BUBBLE_COLLAPSE_EN
        return sp | ~&m.v;
`else
        return sp;
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma <= step(ma, 1'b1, 8'hFF, lsr, sp, di, di_valid);
        mb <= step(mb, 1'b0, 8'h00, lsr, sp, di, di_valid);
    end

    always @(negedge clk) if (chk) begin
        check("a_q", a_q, ma.d[D-1]);
        check("a_qv", W'(a_qv), W'(ma.v[D-1]));
        check("a_fill", W'(a_fill), W'($countones(ma.v)));
        check("a_ready", W'(a_ready), W'(exp_ready(ma)));
        check("b_q", b_q, mb.d[D-1]);
        check("b_qv", W'(b_qv), W'(mb.v[D-1]));
        check("b_fill", W'(b_fill), W'($countones(mb.v)));
        check("b_ready", W'(b_ready), W'(exp_ready(mb)));
    end

    task automatic cyc(input logic l, input logic e, input logic [W-1:0] d, input logic v);
        lsr = l; sp = e; di = d; di_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 1, 8'h00, 0);
        cyc(1, 1, 8'h00, 0);
        chk = 1'b1;
        check("rst_a_q", a_q, 8'hFF);
        check("rst_a_qv", W'(a_qv), 8'h00);
        check("rst_a_fill", W'(a_fill), 8'h00);
        check("rst_b_q", b_q, 8'h00);
        cyc(0, 1, 8'h11, 1);
        check("fill1", W'(a_fill), 8'h01);
        cyc(0, 1, 8'h22, 1);
        check("fill2", W'(a_fill), 8'h02);
        cyc(0, 1, 8'h33, 1);
        check("lat_a_q", a_q, 8'h11);
        check("lat_a_qv", W'(a_qv), 8'h01);
        check("fill3", W'(a_fill), 8'h03);
        check("lat_b_q", b_q, 8'h11);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h44, 1);
        check("stall_q", a_q, 8'h11);
        check("stall_fill", W'(a_fill), 8'h03);
        check("stall_ready", W'(a_ready), 8'h00);
        cyc(0, 1, 8'h44, 0);
        check("drain_q", a_q, 8'h22);
        check("drain_fill", W'(a_fill), 8'h02);
        cyc(0, 1, 8'h00, 0);
        check("drain2_q", a_q, 8'h33);
        check("drain2_fill", W'(a_fill), 8'h01);
        cyc(0, 0, 8'hA5, 1);
        cyc(0, 0, 8'hA5, 1);
        check("bub_q", a_q, 8'h33);
`ifdef TRELLIS_FF_PIPE_BUBBLE_COLLAPSE_EN
        check("bub_fill", W'(a_fill), 8'h03);
`else
        check("bub_fill", W'(a_fill), 8'h01);
`endif
        check("bub_ready", W'(a_ready), 8'h00);
        cyc(1, 0, 8'h00, 0);
        check("lsr_nce_a_q", a_q, 8'hFF);
        check("lsr_nce_a_fill", W'(a_fill), 8'h00);
        check("lsr_nce_b_q", b_q, 8'h33);
        check("lsr_nce_b_qv", W'(b_qv), 8'h00);
        check("lsr_nce_b_fill", W'(b_fill), 8'h00);
        cyc(1, 1, 8'h00, 0);
        check("lsr_ce_b_q", b_q, 8'h00);
        cyc(0, 1, 8'h55, 1);
        cyc(0, 1, 8'h66, 1);
        cyc(1, 1, 8'h77, 1);
        check("drop_fill", W'(a_fill), 8'h00);
        check("drop_q", a_q, 8'hFF);
        cyc(0, 1, 8'h88, 1);
        cyc(0, 1, 8'h99, 1);
        cyc(0, 1, 8'hAA, 1);
        check("restart_a_q", a_q, 8'h88);
        check("restart_a_qv", W'(a_qv), 8'h01);
        check("restart_b_q", b_q, 8'h88);
        check("restart_fill", W'(b_fill), 8'h03);
        cyc(0, 0, 8'h00, 0);
        chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
